xnor_popcount_seq: RTL and testbench

- Multi-cycle sequencer for the TinyML binary-neural-net extension of the Extended DLX.
- Streams LEN pairs of 32-bit operand words from a fetch port through one internal 32-bit XOR unit.
- Optionally inverts each result (XNOR), masks the final word, popcounts, and accumulates.
- Returns a Hamming-distance or match-count scalar to the DLX writeback path with a DONE pulse.

---
 rtl/xnor_popcount_seq.sv | 151 +++++++++++++++
 tb/tb_xnor_popcount_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/xnor_popcount_seq.sv
// XOR/XNOR popcount sequencer for the binary-neural-net DLX extension.
// Fetches LEN operand pairs, accumulates popcount(A^B or ~(A^B)), pulses DONE with the sum.

module xnor_popcount_xor32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    assign y = a ^ b;
endmodule

module xnor_popcount_seq #(
    parameter int LEN_W = 8,
    parameter int ACC_W = LEN_W + 6
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic             ABORT,
    input  logic             MODE,
    input  logic [LEN_W-1:0] LEN,
    input  logic [31:0]      LAST_MASK,
    output logic             REQ,
    output logic [LEN_W-1:0] IDX,
    input  logic             ACK,
    input  logic [31:0]      DATA_A,
    input  logic [31:0]      DATA_B,
    output logic             BUSY,
    output logic             DONE,
    output logic [ACC_W-1:0] RESULT
);
    typedef enum logic [1:0] {IDLE, FETCH, CALC, FIN} state_t;

    localparam logic [LEN_W-1:0] ONE = 1;

    state_t             state, state_nxt;
    logic               mode_q;
    logic [LEN_W-1:0]   len_q;
    logic [31:0]        mask_q, op_a, op_b, x_raw, x_val;
    logic [ACC_W-1:0]   acc, acc_sum;
    logic [5:0]         pop;
    logic               last;

    xnor_popcount_xor32 u_xor (.a(op_a), .b(op_b), .y(x_raw));

    // Last-word test uses the latched LEN, so IDX never needs to wrap.
    always_comb begin
        last  = (IDX == len_q - ONE);
        x_val = mode_q ? ~x_raw : x_raw;
        if (last)
            x_val = x_val & mask_q;
        pop = '0;
        for (int i = 0; i < 32; i++)
            pop = pop + {5'd0, x_val[i]};
        acc_sum = acc + ACC_W'(pop);
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        REQ       = 1'b0;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        case (state)
            IDLE: begin
                if (START)
                    state_nxt = (LEN != '0) ? FETCH : FIN;
            end
            FETCH: begin
                REQ  = 1'b1;
                BUSY = 1'b1;
                if (ABORT)
                    state_nxt = IDLE;
                else if (ACK)
                    state_nxt = CALC;
            end
            CALC: begin
                BUSY = 1'b1;
                if (ABORT)
                    state_nxt = IDLE;
                else
                    state_nxt = last ? FIN : FETCH;
            end
            FIN: begin
                // An abort landing on the completion cycle swallows the pulse.
                DONE      = !ABORT;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            mode_q <= 1'b0;
            len_q  <= '0;
            mask_q <= '0;
            op_a   <= '0;
            op_b   <= '0;
            acc    <= '0;
            IDX    <= '0;
            RESULT <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        mode_q <= MODE;
                        len_q  <= LEN;
                        mask_q <= LAST_MASK;
                        acc    <= '0;
                        IDX    <= '0;
                        if (LEN == '0)
                            RESULT <= '0;
                    end
                end
                FETCH: begin
                    if (ABORT) begin
                        RESULT <= '0;
                        IDX    <= '0;
                    end else if (ACK) begin
                        op_a <= DATA_A;
                        op_b <= DATA_B;
                    end
                end
                CALC: begin
                    if (ABORT) begin
                        RESULT <= '0;
                        IDX    <= '0;
                    end else begin
                        acc <= acc_sum;
                        if (last)
                            RESULT <= acc_sum;
                        else
                            IDX <= IDX + ONE;
                    end
                end
                FIN: begin
                    if (ABORT)
                        RESULT <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_xnor_popcount_seq.sv
// Directed bench for xnor_popcount_seq: table of whole operations plus abort/reset sequences.

module tb_xnor_popcount_seq;
    localparam int LEN_W = 8;
    localparam int ACC_W = 14;

    logic             CLK = 1'b0;
    logic             RESET_N, START, ABORT, MODE, ACK;
    logic [LEN_W-1:0] LEN;
    logic [31:0]      LAST_MASK, DATA_A, DATA_B;
    logic             REQ, BUSY, DONE;
    logic [LEN_W-1:0] IDX;
    logic [ACC_W-1:0] RESULT;

    xnor_popcount_seq #(.LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .ABORT(ABORT), .MODE(MODE),
        .LEN(LEN), .LAST_MASK(LAST_MASK), .REQ(REQ), .IDX(IDX), .ACK(ACK),
        .DATA_A(DATA_A), .DATA_B(DATA_B), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic        mode;
        logic [7:0]  len;
        logic [31:0] mask;
        logic [31:0] a;
        logic [31:0] b;
        int          wait0;
        bit          junk;
        bit          start_mid;
        int          exp;
    } vec_t;

    vec_t tbl[10];
    int   applied = 0;
    int   miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Starts at a negedge in IDLE; returns at a negedge in IDLE after DONE.
    task automatic run_op(input vec_t v);
        int  cyc, word, waitc, exp_cyc;
        bit  done_seen;
        exp_cyc   = (v.len == 0) ? 1 : 2 * v.len + 1 + v.wait0;
        MODE      = v.mode;
        LEN       = v.len;
        LAST_MASK = v.mask;
        START     = 1'b1;
        @(negedge CLK);
        START     = 1'b0;
        MODE      = ~v.mode;
        LEN       = ~v.len;
        LAST_MASK = ~v.mask;
        cyc = 1; word = 0; waitc = 0; done_seen = 0;
        while (!done_seen && cyc < 2000) begin
            if (DONE) begin
                done_seen = 1;
                chk({v.name, " result"}, 32'(RESULT), 32'(v.exp));
                chk({v.name, " latency"}, 32'(cyc), 32'(exp_cyc));
                chk({v.name, " busy@done"}, 32'(BUSY), 32'd0);
            end else begin
                chk({v.name, " busy"}, 32'(BUSY), 32'd1);
                if (REQ) begin
                    chk({v.name, " idx"}, 32'(IDX), 32'(word));
                    if (word == 0 && waitc < v.wait0) begin
                        waitc++;
                        ACK    = 1'b0;
                        DATA_A = 32'hFFFFFFFF;
                        DATA_B = 32'h0;
                    end else begin
                        ACK    = 1'b1;
                        DATA_A = v.a;
                        DATA_B = v.b;
                        word++;
                    end
                end else begin
                    // Would add 32 if the DUT took it.
                    ACK    = v.junk;
                    DATA_A = 32'hFFFFFFFF;
                    DATA_B = 32'h0;
                end
                START = v.start_mid && (cyc == 100);
                @(negedge CLK);
                cyc++;
            end
        end
        chk({v.name, " done seen"}, 32'(done_seen), 32'd1);
        ACK   = 1'b0;
        START = 1'b0;
        @(negedge CLK);
        chk({v.name, " result held"}, 32'(RESULT), 32'(v.exp));
        chk({v.name, " done pulse"}, 32'(DONE), 32'd0);
    endtask

    // Launch LEN=4 all-differing words and leave the bench in cycle 1 (FETCH, word 0).
    task automatic start_len4();
        MODE = 1'b0; LEN = 8'd4; LAST_MASK = 32'hFFFFFFFF; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    initial begin
        bit dn;
        tbl[0] = '{"x1_diff",  1'b0, 8'd1,   32'hFFFFFFFF, 32'hFFFF0000, 32'h0000FFFF, 0, 1'b0, 1'b0, 32};
        tbl[1] = '{"xn1_diff", 1'b1, 8'd1,   32'hFFFFFFFF, 32'hFFFF0000, 32'h0000FFFF, 0, 1'b0, 1'b0, 0};
        tbl[2] = '{"xn3_mask", 1'b1, 8'd3,   32'h0000000F, 32'h12345678, 32'h12345678, 0, 1'b0, 1'b0, 68};
        tbl[3] = '{"x3_mask",  1'b0, 8'd3,   32'h0000000F, 32'h12345678, 32'h12345678, 0, 1'b0, 1'b0, 0};
        tbl[4] = '{"len0",     1'b0, 8'd0,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        0, 1'b0, 1'b0, 0};
        tbl[5] = '{"x2_wait",  1'b0, 8'd2,   32'h0000FFFF, 32'hF0F0F0F0, 32'h0,        5, 1'b1, 1'b0, 24};
        tbl[6] = '{"x2_nowait",1'b0, 8'd2,   32'h0000FFFF, 32'hF0F0F0F0, 32'h0,        0, 1'b0, 1'b0, 24};
        tbl[7] = '{"x2_bit0",  1'b0, 8'd2,   32'h00000001, 32'hAAAAAAAA, 32'h55555555, 0, 1'b1, 1'b0, 33};
        tbl[8] = '{"xn2_bit31",1'b1, 8'd2,   32'h80000000, 32'hAAAAAAAA, 32'h0000FFFF, 0, 1'b0, 1'b0, 16};
        tbl[9] = '{"xn255",    1'b1, 8'd255, 32'hFFFFFFFF, 32'hC3C3C3C3, 32'hC3C3C3C3, 0, 1'b0, 1'b1, 8160};

        RESET_N = 1'b0; START = 1'b0; ABORT = 1'b0; MODE = 1'b0; ACK = 1'b0;
        LEN = '0; LAST_MASK = '0; DATA_A = '0; DATA_B = '0;
        repeat (2) @(negedge CLK);
        chk("rst req", 32'(REQ), 0);
        chk("rst idx", 32'(IDX), 0);
        chk("rst busy", 32'(BUSY), 0);
        chk("rst done", 32'(DONE), 0);
        chk("rst result", 32'(RESULT), 0);
        RESET_N = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 10; i++)
            run_op(tbl[i]);

        // ABORT in IDLE leaves the held result alone.
        run_op(tbl[0]);
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        chk("idle abort result", 32'(RESULT), 32);
        chk("idle abort busy", 32'(BUSY), 0);

        // Abort on word 1 of LEN=4, with a simultaneous ACK that must be dropped.
        start_len4();
        ACK = 1'b1; DATA_A = 32'hFFFFFFFF; DATA_B = 32'h0;
        @(negedge CLK);
        ACK = 1'b0;
        @(negedge CLK);
        chk("abort pre idx", 32'(IDX), 1);
        chk("abort pre req", 32'(REQ), 1);
        ABORT = 1'b1; ACK = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0; ACK = 1'b0;
        chk("abort req", 32'(REQ), 0);
        chk("abort busy", 32'(BUSY), 0);
        chk("abort result", 32'(RESULT), 0);
        dn = 0;
        repeat (8) begin
            @(negedge CLK);
            if (DONE || REQ) dn = 1;
        end
        chk("abort quiet", 32'(dn), 0);
        run_op(tbl[2]);

        // Abort on the FIN cycle suppresses DONE and zeroes RESULT.
        MODE = 1'b0; LEN = 8'd1; LAST_MASK = 32'hFFFFFFFF; START = 1'b1;
        @(negedge CLK);
        START = 1'b0; ACK = 1'b1; DATA_A = 32'hFFFFFFFF; DATA_B = 32'h0;
        @(negedge CLK);
        ACK = 1'b0;
        @(negedge CLK);
        ABORT = 1'b1;
        #1 chk("fin abort done", 32'(DONE), 0);
        @(negedge CLK);
        ABORT = 1'b0;
        chk("fin abort result", 32'(RESULT), 0);
        chk("fin abort busy", 32'(BUSY), 0);

        // Reset in CALC, with START and ACK also high.
        run_op(tbl[0]);
        start_len4();
        ACK = 1'b1; DATA_A = 32'hFFFFFFFF; DATA_B = 32'h0;
        @(negedge CLK);
        ACK = 1'b0;
        chk("calc busy", 32'(BUSY), 1);
        RESET_N = 1'b0; START = 1'b1; ACK = 1'b1;
        @(negedge CLK);
        chk("mid rst req", 32'(REQ), 0);
        chk("mid rst idx", 32'(IDX), 0);
        chk("mid rst busy", 32'(BUSY), 0);
        chk("mid rst done", 32'(DONE), 0);
        chk("mid rst result", 32'(RESULT), 0);
        RESET_N = 1'b1; START = 1'b0; ACK = 1'b0;
        @(negedge CLK);
        chk("post rst idle", 32'(BUSY), 0);
        run_op(tbl[7]);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
